char_buffer_writer: RTL and testbench
=====================================

Name: char_buffer_writer

Overview:
- Fills the character buffer that the text overlay reads. It takes a byte stream (UART RX or a CPU register port) through a valid/ready handshake.
- Keeps a ROWS x COLUMNS character grid with a cursor, and handles CR, LF and backspace, line wrap and scroll-up.
- Drives the grid as a packed character vector straight into the overlay's character input.
- Sits in the pixel clock domain, between the byte source and Text_Overlay.

Parameters:
ROWS, 2, number of character rows in the grid (>=1)
COLUMNS, 10, characters per row (>=2)
NUM_CELLS, ROWS*COLUMNS, derived total cell count; do not override
BLANK_CHAR, 8'h20, code written by reset, clear, scroll fill and backspace

Ports:
i_clk  in  1  pixel clock
i_reset  in  1  asynchronous, active-high reset
i_data  in  8  incoming character or control byte
i_valid  in  1  i_data valid
o_ready  out  1  byte accepted on the cycle where i_valid && o_ready
i_clear  in  1  request to blank the whole grid and home the cursor
o_characters  out  NUM_CELLS*8  packed [NUM_CELLS-1:0][7:0]; cell k = row*COLUMNS+col sits at element NUM_CELLS-1-k, so cell 0 is the most significant byte (string-literal order)
o_cursor_col  out  max(1,$clog2(COLUMNS))  cursor column
o_cursor_row  out  max(1,$clog2(ROWS))  cursor row
o_busy  out  1  high while in SCROLL or CLEAR
o_update  out  1  one-cycle pulse when grid contents finish changing

Behaviour:
- Reset (async):
  - All cells = BLANK_CHAR; cursor = (0,0).
  - state = IDLE; o_busy = 0; o_update = 0; pending clear flag = 0.
- States: IDLE, SCROLL, CLEAR.
- o_ready:
  - o_ready = (state==IDLE) && !i_clear && !pending_clear. This is combinational.
  - Consequence: clear beats a byte presented in the same cycle, and that byte is not accepted.
- Accepted byte in IDLE, all effects on the next clock edge:
  - 0x0D (CR): col = 0. Grid unchanged. No o_update.
  - 0x0A (LF): col = 0.
    - If row < ROWS-1: row + 1.
    - Else: go to SCROLL.
  - 0x08 (BS):
    - If col > 0: col - 1, and that cell = BLANK_CHAR; pulse o_update.
    - If col == 0: no-op, no line un-wrap.
  - Other 0x00-0x1F and 0x7F: ignored, no state change.
  - 0x20-0x7E and 0x80-0xFF: write at the cursor cell and pulse o_update. Then advance:
    - If col < COLUMNS-1: col + 1.
    - Else col = 0, and:
      - If row < ROWS-1: row + 1.
      - Else: go to SCROLL.
- SCROLL:
  - One cell per cycle, index s = 0..NUM_CELLS-1.
  - s < NUM_CELLS-COLUMNS: cell[s] = cell[s+COLUMNS]. Otherwise: cell[s] = BLANK_CHAR.
  - Exactly NUM_CELLS cycles with o_busy=1 and o_ready=0. Cursor stays at (ROWS-1, 0).
  - Pulse o_update on the last cycle, then return to IDLE.
  - ROWS==1: degenerates to blanking the single row.
- CLEAR:
  - Entered from IDLE when i_clear=1, or when pending_clear=1.
  - Writes BLANK_CHAR to cells 0..NUM_CELLS-1, one per cycle, over NUM_CELLS cycles. Cursor = (0,0) on entry.
  - Pulse o_update on the last cycle, then return to IDLE.
- i_clear during SCROLL: sets pending_clear. CLEAR starts on the cycle after SCROLL ends.
- i_clear during CLEAR: ignored.
- Write port: one cell written per cycle at most. Scroll and clear must not use whole-grid combinational copies.
- Cell index arithmetic: row*COLUMNS+col computed at $clog2(NUM_CELLS)+1 bits; no truncation.

Test Plan:
All scenarios use ROWS=2, COLUMNS=10.
1. Reset pulse mid-run -> o_characters = 20 x 8'h20; cursor (0,0); o_ready=1; o_busy=0.
2. Send "Hello, wor" then "l" -> cells 0..9 = "Hello, wor", cell 10 = 'l', cursor (1,1); 11 o_update pulses.
3. Send "ABCDEFGHIJ" then "0123456789" -> after the 20th byte o_ready=0 for exactly 20 cycles; then row0 = "0123456789", row1 = all 0x20, cursor (1,0), one o_update at scroll end.
4. From reset send "AB",0x08 -> cell1=0x20, cursor (0,1). 0x08 x2 -> cursor (0,0), second BS no-op. Move cursor to (0,5), send 0x0D -> cursor (0,0), grid unchanged. 0x07 -> ignored.
5. i_clear and i_valid high in the same IDLE cycle (data 'Z') -> 'Z' not accepted; o_busy high 20 cycles; all cells 0x20; cursor (0,0); single o_update.
6. i_clear pulse during SCROLL -> scroll completes (20 cycles), CLEAR follows (20 cycles), all blank. Async reset asserted at scroll cycle 7 -> grid blank, state IDLE, pending clear dropped.

Source files
------------

// File: rtl/char_buffer_writer.sv
// Character grid writer for the text overlay: accepts bytes over valid/ready,
// tracks a cursor, and handles CR/LF/BS, wrapping, scroll-up and clear.
module char_buffer_writer #(
    parameter int         ROWS       = 2,
    parameter int         COLUMNS    = 10,
    parameter int         NUM_CELLS  = ROWS * COLUMNS,
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    localparam int        COL_W      = (COLUMNS > 1) ? $clog2(COLUMNS) : 1,
    localparam int        ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [7:0]                 i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_clear,
    output logic [NUM_CELLS-1:0][7:0]  o_characters,
    output logic [COL_W-1:0]           o_cursor_col,
    output logic [ROW_W-1:0]           o_cursor_row,
    output logic                       o_busy,
    output logic                       o_update
);

    localparam int               IDX_W      = $clog2(NUM_CELLS) + 1;
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLUMNS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CELLS - 1);
    localparam logic [IDX_W-1:0] KEEP_CELLS = IDX_W'(NUM_CELLS - COLUMNS);
    localparam logic [IDX_W-1:0] ROW_STRIDE = IDX_W'(COLUMNS);
    localparam logic [7:0]       CHAR_CR    = 8'h0D;
    localparam logic [7:0]       CHAR_LF    = 8'h0A;
    localparam logic [7:0]       CHAR_BS    = 8'h08;

    typedef enum logic [1:0] {
        IDLE,
        SCROLL,
        CLEAR
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [IDX_W-1:0] step;
    logic             pending_clear;

    logic [7:0]       cells [NUM_CELLS];
    logic             is_print;
    logic [IDX_W-1:0] cursor_idx;
    logic [IDX_W-1:0] src_idx;
    logic [7:0]       src_data;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       wr_data;

    assign o_ready      = (state == IDLE) && !i_clear && !pending_clear;
    assign o_busy       = (state != IDLE);
    assign o_cursor_row = row;
    assign o_cursor_col = col;

    always_comb begin
        is_print   = (i_data >= 8'h20) && (i_data != 8'h7F);
        cursor_idx = IDX_W'(row) * ROW_STRIDE + IDX_W'(col);
        src_idx    = step + ROW_STRIDE;
        src_data   = BLANK_CHAR;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (src_idx == IDX_W'(k)) src_data = cells[k];
        end
    end

    // Single grid write port: typed characters and backspace in IDLE,
    // one cell per cycle while scrolling or clearing.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cursor_idx;
        wr_data = BLANK_CHAR;
        case (state)
            IDLE: begin
                if (o_ready && i_valid) begin
                    if (is_print) begin
                        wr_en   = 1'b1;
                        wr_data = i_data;
                    end else if (i_data == CHAR_BS && col != '0) begin
                        wr_en  = 1'b1;
                        wr_idx = cursor_idx - IDX_W'(1);
                    end
                end
            end
            SCROLL: begin
                wr_en   = 1'b1;
                wr_idx  = step;
                wr_data = (step < KEEP_CELLS) ? src_data : BLANK_CHAR;
            end
            CLEAR: begin
                wr_en  = 1'b1;
                wr_idx = step;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_CELLS; k++) cells[k] <= BLANK_CHAR;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_CELLS; k++) begin
                if (wr_idx == IDX_W'(k)) cells[k] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_CELLS; k++) begin : g_out
        assign o_characters[NUM_CELLS-1-k] = cells[k];
    end

    // o_update is registered, so it is high in the first cycle the new grid is visible.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            row           <= '0;
            col           <= '0;
            step          <= '0;
            pending_clear <= 1'b0;
            o_update      <= 1'b0;
        end else begin
            o_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_clear || pending_clear) begin
                        state         <= CLEAR;
                        row           <= '0;
                        col           <= '0;
                        step          <= '0;
                        pending_clear <= 1'b0;
                    end else if (i_valid) begin
                        if (i_data == CHAR_CR) begin
                            col <= '0;
                        end else if (i_data == CHAR_LF) begin
                            col <= '0;
                            if (row != LAST_ROW) begin
                                row <= row + ROW_W'(1);
                            end else begin
                                state <= SCROLL;
                                step  <= '0;
                            end
                        end else if (i_data == CHAR_BS) begin
                            if (col != '0) begin
                                col      <= col - COL_W'(1);
                                o_update <= 1'b1;
                            end
                        end else if (is_print) begin
                            o_update <= 1'b1;
                            if (col != LAST_COL) begin
                                col <= col + COL_W'(1);
                            end else begin
                                col <= '0;
                                if (row != LAST_ROW) begin
                                    row <= row + ROW_W'(1);
                                end else begin
                                    state <= SCROLL;
                                    step  <= '0;
                                end
                            end
                        end
                    end
                end
                SCROLL: begin
                    if (i_clear) pending_clear <= 1'b1;
                    if (step == LAST_IDX) begin
                        state    <= IDLE;
                        o_update <= 1'b1;
                    end else begin
                        step <= step + IDX_W'(1);
                    end
                end
                CLEAR: begin
                    if (step == LAST_IDX) begin
                        state    <= IDLE;
                        o_update <= 1'b1;
                    end else begin
                        step <= step + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_buffer_writer.sv
// Self-checking bench for char_buffer_writer: a grid-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_char_buffer_writer;

    localparam int ROWS      = 2;
    localparam int COLUMNS   = 10;
    localparam int NUM_CELLS = ROWS * COLUMNS;
    localparam int K_SCROLL  = 1;
    localparam int K_CLEAR   = 2;

    typedef logic [159:0] vec_t;

    logic                      i_clk = 1'b0;
    logic                      i_reset;
    logic [7:0]                i_data;
    logic                      i_valid;
    logic                      i_clear;
    logic                      o_ready;
    logic [NUM_CELLS-1:0][7:0] o_characters;
    logic [3:0]                o_cursor_col;
    logic [0:0]                o_cursor_row;
    logic                      o_busy;
    logic                      o_update;

    always #5 i_clk = ~i_clk;

    char_buffer_writer #(
        .ROWS      (ROWS),
        .COLUMNS   (COLUMNS),
        .BLANK_CHAR(8'h20)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_clear     (i_clear),
        .o_characters(o_characters),
        .o_cursor_col(o_cursor_col),
        .o_cursor_row(o_cursor_row),
        .o_busy      (o_busy),
        .o_update    (o_update)
    );

    int vectors     = 0;
    int miscompares = 0;
    int upd_count   = 0;
    bit cmp_en      = 1'b0;

    task automatic checkOutput(input string name, input vec_t actual, input vec_t expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Grid-level model: scroll and clear take effect as whole-grid operations
    // when their busy period ends; the grid is only compared while idle.
    logic [7:0] m_grid [NUM_CELLS];
    int         m_row, m_col, m_busy_left, m_kind;
    bit         m_pending, m_update;

    function automatic vec_t packModel();
        vec_t v = '0;
        for (int k = 0; k < NUM_CELLS; k++) v[159-8*k -: 8] = m_grid[k];
        return v;
    endfunction

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_CELLS; k++) m_grid[k] = 8'h20;
            m_row = 0; m_col = 0; m_busy_left = 0; m_kind = 0;
            m_pending = 1'b0; m_update = 1'b0;
        end else begin
            m_update = 1'b0;
            if (m_busy_left > 0) begin
                if (m_kind == K_SCROLL && i_clear) m_pending = 1'b1;
                m_busy_left--;
                if (m_busy_left == 0) begin
                    for (int k = 0; k < NUM_CELLS; k++) begin
                        if (m_kind == K_SCROLL && k + COLUMNS < NUM_CELLS) m_grid[k] = m_grid[k+COLUMNS];
                        else m_grid[k] = 8'h20;
                    end
                    m_update = 1'b1;
                end
            end else if (i_clear || m_pending) begin
                m_kind = K_CLEAR; m_busy_left = NUM_CELLS;
                m_row = 0; m_col = 0; m_pending = 1'b0;
            end else if (i_valid) begin
                if (i_data == 8'h0D) begin
                    m_col = 0;
                end else if (i_data == 8'h0A) begin
                    m_col = 0;
                    if (m_row < ROWS - 1) m_row++;
                    else begin m_kind = K_SCROLL; m_busy_left = NUM_CELLS; end
                end else if (i_data == 8'h08) begin
                    if (m_col > 0) begin
                        m_col--;
                        m_grid[m_row*COLUMNS+m_col] = 8'h20;
                        m_update = 1'b1;
                    end
                end else if (i_data >= 8'h20 && i_data != 8'h7F) begin
                    m_grid[m_row*COLUMNS+m_col] = i_data;
                    m_update = 1'b1;
                    m_col++;
                    if (m_col == COLUMNS) begin
                        m_col = 0;
                        if (m_row < ROWS - 1) m_row++;
                        else begin m_kind = K_SCROLL; m_busy_left = NUM_CELLS; end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-way between clock edges.
    always begin
        @(negedge i_clk);
        #2;
        if (cmp_en) begin
            checkOutput("ready", vec_t'(o_ready), vec_t'((m_busy_left == 0) && !i_clear && !m_pending));
            checkOutput("busy", vec_t'(o_busy), vec_t'(m_busy_left != 0));
            checkOutput("update", vec_t'(o_update), vec_t'(m_update));
            checkOutput("cursor_row", vec_t'(o_cursor_row), vec_t'(m_row));
            checkOutput("cursor_col", vec_t'(o_cursor_col), vec_t'(m_col));
            if (m_busy_left == 0) checkOutput("grid", vec_t'(o_characters), packModel());
        end
    end

    always @(negedge i_clk) begin
        if (o_update === 1'b1) upd_count++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] b);
        int n = 0;
        @(negedge i_clk);
        i_data  = b;
        i_valid = 1'b1;
        #1;
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (!o_ready) checkOutput("handshake_ready", vec_t'(o_ready), vec_t'(1));
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic applyString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    task automatic pulseReset();
        @(negedge i_clk);
        #3 i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        #3 i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic settle();
        repeat (2) @(negedge i_clk);
        #1;
    endtask

    // Counts cycles with o_ready low (watch_ready=1) or o_busy high (watch_ready=0).
    task automatic countLow(input bit watch_ready, output int n);
        n = 0;
        #1;
        while ((watch_ready ? !o_ready : o_busy) && n < 200) begin
            n++;
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic checkCursor(input string name, input int row, input int col);
        checkOutput(name, vec_t'({o_cursor_row, o_cursor_col}), vec_t'({row[0:0], col[3:0]}));
    endtask

    vec_t blanks;
    int   n, base;

    initial begin
        blanks  = {20{8'h20}};
        i_reset = 1'b1;
        i_data  = 8'h00;
        i_valid = 1'b0;
        i_clear = 1'b0;
        repeat (2) @(posedge i_clk);
        cmp_en = 1'b1;
        @(negedge i_clk);
        #3 i_reset = 1'b0;

        // 1: reset pulse mid-run
        applyString("Hi");
        pulseReset();
        #1;
        checkOutput("t1_grid", vec_t'(o_characters), blanks);
        checkCursor("t1_cursor", 0, 0);
        checkOutput("t1_ready", vec_t'(o_ready), vec_t'(1));
        checkOutput("t1_busy", vec_t'(o_busy), vec_t'(0));

        // 2: wrap onto the second row
        base = upd_count;
        applyString("Hello, wor");
        applyStimulus("l");
        settle();
        checkOutput("t2_grid", vec_t'(o_characters), vec_t'("Hello, worl         "));
        checkCursor("t2_cursor", 1, 1);
        checkOutput("t2_updates", vec_t'(upd_count - base), vec_t'(11));

        // 3: fill both rows, scroll up
        pulseReset();
        base = upd_count;
        applyString("ABCDEFGHIJ");
        applyString("012345678");
        applyStimulus("9");
        countLow(1'b1, n);
        checkOutput("t3_ready_low", vec_t'(n), vec_t'(20));
        settle();
        checkOutput("t3_grid", vec_t'(o_characters), vec_t'("0123456789          "));
        checkOutput("t3_model", packModel(), vec_t'("0123456789          "));
        checkCursor("t3_cursor", 1, 0);
        checkOutput("t3_updates", vec_t'(upd_count - base), vec_t'(21));

        // 4: backspace, CR, ignored control codes, LF
        pulseReset();
        base = upd_count;
        applyString("AB");
        applyStimulus(8'h08);
        settle();
        checkOutput("t4_bs_grid", vec_t'(o_characters), vec_t'("A                   "));
        checkCursor("t4_bs_cursor", 0, 1);
        applyStimulus(8'h08);
        applyStimulus(8'h08);
        settle();
        checkOutput("t4_bs2_grid", vec_t'(o_characters), blanks);
        checkCursor("t4_bs2_cursor", 0, 0);
        checkOutput("t4_bs_updates", vec_t'(upd_count - base), vec_t'(4));
        applyString("xyzuv");
        settle();
        checkCursor("t4_move_cursor", 0, 5);
        base = upd_count;
        applyStimulus(8'h0D);
        settle();
        checkCursor("t4_cr_cursor", 0, 0);
        checkOutput("t4_cr_grid", vec_t'(o_characters), vec_t'("xyzuv               "));
        applyStimulus(8'h07);
        applyStimulus(8'h7F);
        settle();
        checkCursor("t4_ctl_cursor", 0, 0);
        checkOutput("t4_ctl_grid", vec_t'(o_characters), vec_t'("xyzuv               "));
        checkOutput("t4_ctl_updates", vec_t'(upd_count - base), vec_t'(0));
        applyStimulus(8'h0A);
        settle();
        checkCursor("t4_lf_cursor", 1, 0);

        // 5: clear beats a byte offered in the same cycle
        base = upd_count;
        @(negedge i_clk);
        i_data  = "Z";
        i_valid = 1'b1;
        i_clear = 1'b1;
        #1;
        checkOutput("t5_ready_blocked", vec_t'(o_ready), vec_t'(0));
        @(negedge i_clk);
        i_valid = 1'b0;
        i_clear = 1'b0;
        countLow(1'b0, n);
        checkOutput("t5_busy_cycles", vec_t'(n), vec_t'(20));
        settle();
        checkOutput("t5_grid", vec_t'(o_characters), blanks);
        checkCursor("t5_cursor", 0, 0);
        checkOutput("t5_updates", vec_t'(upd_count - base), vec_t'(1));

        // 6a: clear during scroll is deferred until the scroll completes
        applyString("ABCDEFGHIJ");
        applyString("KLMNOPQRS");
        applyStimulus("T");
        repeat (4) @(negedge i_clk);
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        countLow(1'b1, n);
        checkOutput("t6_ready_low", vec_t'(n), vec_t'(36));
        settle();
        checkOutput("t6_grid", vec_t'(o_characters), blanks);
        checkCursor("t6_cursor", 0, 0);

        // 6b: async reset mid-scroll drops the pending clear
        applyString("abcdefghij");
        applyString("klmnopqrs");
        applyStimulus("t");
        repeat (2) @(negedge i_clk);
        i_clear = 1'b1;
        @(negedge i_clk);
        i_clear = 1'b0;
        repeat (3) @(negedge i_clk);
        #3 i_reset = 1'b1;
        @(negedge i_clk);
        #3 i_reset = 1'b0;
        settle();
        checkOutput("t6_rst_grid", vec_t'(o_characters), blanks);
        checkOutput("t6_rst_ready", vec_t'(o_ready), vec_t'(1));
        checkOutput("t6_rst_busy", vec_t'(o_busy), vec_t'(0));
        checkCursor("t6_rst_cursor", 0, 0);
        repeat (3) @(negedge i_clk);
        #1;
        checkOutput("t6_no_pending_clear", vec_t'(o_busy), vec_t'(0));

        settle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
